dino_motion_ctrl: RTL and testbench

Frame-synchronous motion controller for the player dinosaur. It detects the start of each vertical sync pulse and advances a run/duck/jump state machine with integer jump physics. It then acts as a bus master into the sprite display peripheral's register port, writing the X/Y coordinates of the three player sprites (run, jump, duck). The sprite for the active pose is placed at the dino position; the two inactive sprites are parked off-screen.

---
 rtl/dino_motion_ctrl.sv | 131 +++++++++++++
 tb/tb_dino_motion_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dino_motion_ctrl.sv
// Player dinosaur motion controller: per-frame run/duck/jump physics, then a six-beat
// register-write burst that places the active pose sprite and parks the other two.
module dino_motion_ctrl #(
    parameter logic [7:0] DINO_X      = 8'd40,
    parameter logic [7:0] GROUND_Y    = 8'd100,
    parameter logic [7:0] JUMP_V0     = 8'd12,
    parameter logic [7:0] GRAVITY     = 8'd1,
    parameter logic [7:0] OFFSCREEN_Y = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vga_vs,
    input  logic        run_en,
    input  logic        jump_req,
    input  logic        duck_req,
    output logic        chipselect,
    output logic        write,
    output logic [8:0]  address,
    output logic [31:0] writedata,
    output logic [7:0]  dino_y,
    output logic [1:0]  pose,
    output logic        busy
);

    typedef enum logic [1:0] {
        PoseRun  = 2'd0,
        PoseDuck = 2'd1,
        PoseAir  = 2'd2
    } pose_e;

    pose_e             pose_q, pose_d;
    logic [7:0]        h_q, h_d;
    logic signed [8:0] v_q, v_d;
    logic              vs_d;
    logic              jump_pend;
    logic              busy_q;
    logic [2:0]        beat_q;
    logic              frame_tick;
    logic              update;
    logic              jump_now;
    logic signed [9:0] n_sum;
    logic [7:0]        beat_val;

    assign frame_tick = vs_d & ~vga_vs;
    // Ticks landing inside a burst are dropped entirely.
    assign update     = frame_tick & run_en & ~busy_q;
    // A request arriving in the tick cycle itself is consumed by that tick.
    assign jump_now   = jump_pend | jump_req;
    assign n_sum      = $signed({2'b00, h_q}) + $signed({v_q[8], v_q});

    always_comb begin
        pose_d = pose_q;
        h_d    = h_q;
        v_d    = v_q;
        if (update) begin
            case (pose_q)
                PoseRun, PoseDuck: begin
                    if (jump_now) begin
                        pose_d = PoseAir;
                        h_d    = 8'd0;
                        v_d    = $signed({1'b0, JUMP_V0});
                    end else if (pose_q == PoseRun && duck_req) begin
                        pose_d = PoseDuck;
                    end else if (pose_q == PoseDuck && !duck_req) begin
                        pose_d = PoseRun;
                    end
                end
                PoseAir: begin
                    if (n_sum <= 10'sd0) begin
                        h_d    = 8'd0;
                        v_d    = 9'sd0;
                        pose_d = duck_req ? PoseDuck : PoseRun;
                    end else begin
                        h_d = (n_sum > $signed({2'b00, GROUND_Y})) ? GROUND_Y : n_sum[7:0];
                        v_d = v_q - $signed({1'b0, GRAVITY});
                    end
                end
                default: pose_d = PoseRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pose_q    <= PoseRun;
            h_q       <= 8'd0;
            v_q       <= 9'sd0;
            vs_d      <= 1'b1;
            jump_pend <= 1'b0;
            busy_q    <= 1'b0;
            beat_q    <= 3'd0;
        end else begin
            pose_q    <= pose_d;
            h_q       <= h_d;
            v_q       <= v_d;
            vs_d      <= vga_vs;
            jump_pend <= frame_tick ? 1'b0 : jump_now;
            if (update) begin
                busy_q <= 1'b1;
                beat_q <= 3'd0;
            end else if (busy_q) begin
                if (beat_q == 3'd5) begin
                    busy_q <= 1'b0;
                    beat_q <= 3'd0;
                end else begin
                    beat_q <= beat_q + 3'd1;
                end
            end
        end
    end

    always_comb begin
        beat_val = 8'd0;
        case (beat_q)
            3'd0, 3'd2, 3'd4: beat_val = DINO_X;
            3'd1:    beat_val = (pose_q == PoseRun)  ? dino_y : OFFSCREEN_Y;
            3'd3:    beat_val = (pose_q == PoseAir)  ? dino_y : OFFSCREEN_Y;
            3'd5:    beat_val = (pose_q == PoseDuck) ? dino_y : OFFSCREEN_Y;
            default: beat_val = 8'd0;
        endcase
    end

    assign dino_y     = GROUND_Y - h_q;
    assign pose       = pose_q;
    assign busy       = busy_q;
    assign chipselect = busy_q;
    assign write      = busy_q;
    assign address    = busy_q ? {6'd0, beat_q} : 9'd0;
    assign writedata  = busy_q ? {24'd0, beat_val} : 32'd0;

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed bench for dino_motion_ctrl: idle, jump, duck, clamp, gating and mid-burst reset.
module tb_dino_motion_ctrl;

    logic        clk;
    logic        reset;
    logic        vga_vs;
    logic        run_en;
    logic        jump_req;
    logic        duck_req;
    logic        chipselect, write, busy;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic [7:0]  dino_y;
    logic [1:0]  pose;
    logic        cs2, wr2, busy2;
    logic [8:0]  addr2;
    logic [31:0] wd2;
    logic [7:0]  dino_y2;
    logic [1:0]  pose2;

    int total = 0;
    int bad   = 0;
    int n_wr;
    int n_busy;
    logic [7:0] y1, y3, y5;

    dino_motion_ctrl dut (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .run_en(run_en),
        .jump_req(jump_req), .duck_req(duck_req), .chipselect(chipselect),
        .write(write), .address(address), .writedata(writedata),
        .dino_y(dino_y), .pose(pose), .busy(busy)
    );

    dino_motion_ctrl #(.JUMP_V0(8'd200), .GROUND_Y(8'd100)) dut_clamp (
        .clk(clk), .reset(reset), .vga_vs(vga_vs), .run_en(run_en),
        .jump_req(jump_req), .duck_req(duck_req), .chipselect(cs2),
        .write(wr2), .address(addr2), .writedata(wd2),
        .dino_y(dino_y2), .pose(pose2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_jump();
        @(negedge clk); jump_req = 1'b1;
        @(negedge clk); jump_req = 1'b0;
    endtask

    // One vsync falling edge, then observe the following 8 cycles of bus activity.
    task automatic frame(input bit jr);
        @(negedge clk); vga_vs = 1'b0; jump_req = jr;
        @(negedge clk); vga_vs = 1'b1; jump_req = 1'b0;
        n_wr = 0; n_busy = 0; y1 = 8'd0; y3 = 8'd0; y5 = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (write)      n_wr++;
            if (busy)       n_busy++;
            if (i < 6 && write) begin
                chk("beat_addr", {23'd0, address}, i);
                if (i % 2 == 0) chk("beat_x", writedata, 32'd40);
                else if (i == 1) y1 = writedata[7:0];
                else if (i == 3) y3 = writedata[7:0];
                else             y5 = writedata[7:0];
            end
            if (i == 7) begin
                chk("idle_addr", {23'd0, address}, 0);
                chk("idle_data", writedata, 0);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; vga_vs = 1'b1; run_en = 1'b1; jump_req = 1'b0; duck_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pose", pose, 0);
        chk("rst_dino_y", dino_y, 100);
        chk("rst_busy", busy, 0);
        chk("rst_cs", chipselect, 0);
        chk("rst_write", write, 0);
        chk("rst_addr", address, 0);
        chk("rst_data", writedata, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Idle frame
        frame(1'b0);
        chk("idle_nwr", n_wr, 6);
        chk("idle_nbusy", n_busy, 6);
        chk("idle_y1", y1, 100);
        chk("idle_y3", y3, 255);
        chk("idle_y5", y5, 255);
        chk("idle_pose", pose, 0);

        // Jump trajectory; latched request, then a mid-air request that must be ignored
        pulse_jump();
        frame(1'b0);
        chk("jmp0_pose", pose, 2);
        chk("jmp0_dino_y", dino_y, 100);
        chk("jmp0_y1", y1, 255);
        chk("jmp0_y3", y3, 100);
        chk("jmp0_y5", y5, 255);
        for (int k = 1; k <= 25; k++) begin
            if (k == 7) pulse_jump();
            frame(1'b0);
            case (k)
                1: begin
                    chk("clamp1_dino_y", dino_y2, 0);
                    chk("clamp1_pose", pose2, 2);
                end
                2: chk("clamp2_dino_y", dino_y2, 0);
                7: chk("air7_dino_y", dino_y, 37);
                12: begin
                    chk("air12_dino_y", dino_y, 22);
                    chk("air12_y1", y1, 255);
                    chk("air12_y3", y3, 22);
                    chk("air12_y5", y5, 255);
                end
                13: chk("air13_dino_y", dino_y, 22);
                24: begin
                    chk("air24_pose", pose, 2);
                    chk("air24_dino_y", dino_y, 88);
                end
                25: begin
                    chk("land_pose", pose, 0);
                    chk("land_dino_y", dino_y, 100);
                end
                default: ;
            endcase
        end
        frame(1'b0);
        chk("post_land_pose", pose, 0);

        // Duck, jump from duck with same-cycle request, land while still ducking
        duck_req = 1'b1;
        frame(1'b0);
        chk("duck_pose", pose, 1);
        chk("duck_y1", y1, 255);
        chk("duck_y3", y3, 255);
        chk("duck_y5", y5, 100);
        frame(1'b1);
        chk("duckjmp_pose", pose, 2);
        chk("duckjmp_dino_y", dino_y, 100);
        for (int k = 1; k <= 25; k++) begin
            frame(1'b0);
            if (k == 24) chk("dair24_pose", pose, 2);
            if (k == 25) begin
                chk("dland_pose", pose, 1);
                chk("dland_dino_y", dino_y, 100);
            end
        end
        duck_req = 1'b0;
        frame(1'b0);
        chk("unduck_pose", pose, 0);

        // Gating: frozen state, no strobes, pending jump cleared by the ticks
        run_en = 1'b0;
        pulse_jump();
        for (int k = 0; k < 3; k++) begin
            frame(1'b0);
            chk("gate_nwr", n_wr, 0);
            chk("gate_nbusy", n_busy, 0);
            chk("gate_pose", pose, 0);
            chk("gate_dino_y", dino_y, 100);
        end
        run_en = 1'b1;
        frame(1'b0);
        chk("ungate_nwr", n_wr, 6);
        chk("ungate_pose", pose, 0);

        // Reset in the middle of an AIR burst
        pulse_jump();
        @(negedge clk); vga_vs = 1'b0;
        @(negedge clk); vga_vs = 1'b1;
        @(negedge clk);
        chk("mid_pose", pose, 2);
        chk("mid_write", write, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_cs", chipselect, 0);
        chk("arst_write", write, 0);
        chk("arst_busy", busy, 0);
        chk("arst_addr", address, 0);
        chk("arst_data", writedata, 0);
        chk("arst_pose", pose, 0);
        chk("arst_dino_y", dino_y, 100);
        @(negedge clk); reset = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (write) n_wr++;
        end
        chk("post_rst_nwr", n_wr, 0);
        frame(1'b0);
        chk("post_rst_frame_nwr", n_wr, 6);
        chk("post_rst_frame_y1", y1, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
